// File: rtl/spi_pkg.sv
// Shared SPI-side definitions: arbiter state encoding, packet header tag,
// and the opcode constants decoded by the SPI slave command parser.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PASS   = 2'd2
    } arb_state_t;

    // Upper nibble of the optional per-packet source-ID header byte.
    localparam logic [3:0] ARB_HDR_TAG = 4'hA;

    // SPI slave command opcodes.
    localparam logic [7:0] SPI_OP_WRITE  = 8'h02;
    localparam logic [7:0] SPI_OP_READ   = 8'h03;
    localparam logic [7:0] SPI_OP_STATUS = 8'h05;
    localparam logic [7:0] SPI_OP_EVENT  = 8'h0B;
    localparam logic [7:0] SPI_OP_RESET  = 8'hFF;

    // Round-robin successor of a source index, modulo n.
    function automatic logic [3:0] rr_next(input logic [3:0] idx, input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first asserted
// request at or above ptr (wrapping), as a one-hot vector and an index.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [3:0]   idx,
    output logic         any
);

    logic [N-1:0] rot;
    int unsigned  sel;

    // Rotate requests so ptr lands at bit 0, take the lowest set bit,
    // then map the rotated position back to an absolute index.
    always_comb begin
        rot = N'({req, req} >> ptr);
        sel = 0;
        any = 1'b0;
        idx = '0;
        gnt = '0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!any && rot[off]) begin
                any = 1'b1;
                sel = 32'(ptr) + off;
                if (sel >= N) begin
                    sel = sel - N;
                end
                idx = 4'(sel);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            gnt[i] = any && (idx == 4'(i));
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: packet-level round-robin arbiter that shares the SPI
// slave's device-to-host byte stream between NUM_SRC producers. Packets stay
// contiguous; stalled producers are aborted after STALL_TIMEOUT idle cycles
// and flush (SPI reset) drops any packet in progress.
// Define SPI_ARB_HEADER_EN to prefix every packet with {ARB_HDR_TAG, id}.
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_vld,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_rdy,
    output logic [7:0]           out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 stall_err
);

    arb_state_t         state, state_n;
    logic [NUM_SRC-1:0] grant_r, grant_n;
    logic [3:0]         gidx, gidx_n;
    logic [3:0]         ptr, ptr_n;
    logic [7:0]         cnt, cnt_n, cnt_inc;
    logic               serr_r, serr_n;

    logic [NUM_SRC-1:0] pick_gnt;
    logic [3:0]         pick_idx;
    logic               pick_any;

    logic               g_vld;
    logic               g_last;
    logic [7:0]         g_data;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req (src_vld),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant     = grant_r;
    assign busy      = (state != IDLE);
    assign stall_err = serr_r;

    // State, ownership, pointer, stall counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_r <= '0;
            gidx    <= '0;
            ptr     <= '0;
            cnt     <= '0;
            serr_r  <= 1'b0;
        end else begin
            state   <= state_n;
            grant_r <= grant_n;
            gidx    <= gidx_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            serr_r  <= serr_n;
        end
    end

    // Next-state and output decode; the granted source is selected through
    // the one-hot grant mask so no variable bit-select is needed.
    always_comb begin
        state_n  = state;
        grant_n  = grant_r;
        gidx_n   = gidx;
        ptr_n    = ptr;
        cnt_n    = cnt;
        serr_n   = 1'b0;
        out_data = '0;
        out_vld  = 1'b0;
        src_rdy  = '0;
        cnt_inc  = cnt + 8'd1;

        g_vld  = |(src_vld & grant_r);
        g_last = |(src_last & grant_r);
        g_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_r[i]) begin
                g_data = src_data[8*i +: 8];
            end
        end

        if (flush) begin
            state_n = IDLE;
            grant_n = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_n = pick_gnt;
                        gidx_n  = pick_idx;
                        cnt_n   = '0;
`ifdef SPI_ARB_HEADER_EN
                        state_n = HEADER;
`else
                        state_n = PASS;
`endif
                    end
                end
`ifdef SPI_ARB_HEADER_EN
                HEADER: begin
                    out_vld  = 1'b1;
                    out_data = {ARB_HDR_TAG, gidx};
                    if (out_rdy) begin
                        state_n = PASS;
                    end
                end
`endif
                PASS: begin
                    out_data = g_data;
                    out_vld  = g_vld;
                    src_rdy  = grant_r & {NUM_SRC{out_rdy}};
                    if (g_vld) begin
                        cnt_n = '0;
                        if (out_rdy && g_last) begin
                            state_n = IDLE;
                            grant_n = '0;
                            ptr_n   = rr_next(gidx, NUM_SRC);
                        end
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == 8'(STALL_TIMEOUT)) begin
                            serr_n  = 1'b1;
                            state_n = IDLE;
                            grant_n = '0;
                            cnt_n   = '0;
                            ptr_n   = rr_next(gidx, NUM_SRC);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter (NUM_SRC=4, STALL_TIMEOUT=4).
// Sources replay per-source byte queues; a packet-level reference model
// predicts ownership, outputs and stall aborts cycle by cycle.
module tb_spi_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int          NI  = 4;
    localparam int          TMO = 4;
`ifdef SPI_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           flush = 1'b0;
    logic [N*8-1:0] src_data = '0;
    logic [N-1:0]   src_vld = '0;
    logic [N-1:0]   src_last = '0;
    logic [N-1:0]   src_rdy;
    logic [7:0]     out_data;
    logic           out_vld;
    logic           out_rdy = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           stall_err;

    always #5 clk = ~clk;

    spi_tx_arbiter #(.NUM_SRC(N), .STALL_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .src_data  (src_data),
        .src_vld   (src_vld),
        .src_last  (src_last),
        .src_rdy   (src_rdy),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .grant     (grant),
        .busy      (busy),
        .stall_err (stall_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-source byte queues: {last, data}
    logic [8:0] mem [N][512];
    int head [N];
    int tail [N];

    // Reference model state
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_hdr;
    bit m_serr;

    // Stimulus knobs
    int unsigned  p_vld, p_rdy, p_flush;
    logic [N-1:0] hold;
    bit           flush_now;

    // Observations of the DUT
    logic [7:0]   cap [64];
    int           cap_n;
    int           glog [64];
    int           glog_n;
    logic [N-1:0] prev_grant;
    int           serr_cnt;
    int           gcyc;

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < NI; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push(input int s, input logic [7:0] d, input logic l);
        mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1; flush = 1'b0; out_rdy = 1'b0;
        src_vld = '0; src_last = '0; src_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall_err", 32'(stall_err), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_src_rdy", 32'(src_rdy), 0);
        reset = 1'b0;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_hdr = 0; m_serr = 0;
        for (int i = 0; i < NI; i++) begin head[i] = 0; tail[i] = 0; end
        hold = '0; flush_now = 0;
        cap_n = 0; glog_n = 0; serr_cnt = 0; gcyc = 0; prev_grant = '0;
        p_vld = 100; p_rdy = 100; p_flush = 0;
    endtask

    // One clock cycle: drive, predict, check, then advance the model.
    task automatic step();
        logic [N-1:0] e_grant, e_rdy;
        logic         e_vld;
        logic [7:0]   e_data;
        int           nx;
        @(posedge clk); #1;
        reset   = 1'b0;
        flush   = flush_now || ($urandom_range(99) < p_flush);
        out_rdy = ($urandom_range(99) < p_rdy);
        for (int i = 0; i < NI; i++) begin
            if (head[i] < tail[i] && !hold[i] && $urandom_range(99) < p_vld) begin
                src_vld[i]        = 1'b1;
                src_data[8*i +: 8] = mem[i][head[i]][7:0];
                src_last[i]       = mem[i][head[i]][8];
            end else begin
                src_vld[i]        = 1'b0;
                src_data[8*i +: 8] = 8'($urandom);
                src_last[i]       = 1'($urandom_range(1));
            end
        end

        e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_vld = 1'b0; e_rdy = '0; e_data = '0;
        if (!flush && m_owner >= 0) begin
            if (m_hdr) begin
                e_vld  = 1'b1;
                e_data = {4'hA, 4'(m_owner)};
            end else begin
                e_vld  = src_vld[m_owner];
                e_data = src_data[8*m_owner +: 8];
                if (out_rdy) e_rdy = e_grant;
            end
        end

        @(negedge clk);
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("stall_err", 32'(stall_err), 32'(m_serr));
        chk("out_vld", 32'(out_vld), 32'(e_vld));
        chk("src_rdy", 32'(src_rdy), 32'(e_rdy));
        if (e_vld) chk("out_data", 32'(out_data), 32'(e_data));

        if (stall_err) serr_cnt++;
        if (grant == 4'b0100) gcyc++;
        if (grant != '0 && grant != prev_grant) begin
            if (glog_n < 64) glog[glog_n] = oh_idx(grant);
            glog_n++;
        end
        prev_grant = grant;
        if (out_vld && out_rdy) begin
            if (cap_n < 64) cap[cap_n] = out_data;
            cap_n++;
        end

        for (int i = 0; i < NI; i++) if (e_rdy[i] && src_vld[i]) head[i]++;

        m_serr = 0;
        if (flush) begin
            m_owner = -1; m_hdr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NI; k++) begin
                nx = (m_ptr + k) % NI;
                if (m_owner < 0 && src_vld[nx]) m_owner = nx;
            end
            if (m_owner >= 0) begin m_hdr = (HDR != 0); m_cnt = 0; end
        end else if (m_hdr) begin
            if (out_rdy) m_hdr = 0;
        end else if (src_vld[m_owner]) begin
            m_cnt = 0;
            if (out_rdy && src_last[m_owner]) begin
                m_ptr = (m_owner + 1) % NI;
                m_owner = -1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == TMO) begin
                m_serr = 1;
                m_ptr = (m_owner + 1) % NI;
                m_owner = -1;
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        int left;

        // Single packet from source 2
        reset_dut();
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
        repeat (10) step();
        chk("single_len", 32'(cap_n), 32'(3 + HDR));
        if (HDR != 0) chk("single_hdr", 32'(cap[0]), 32'h A2);
        chk("single_b0", 32'(cap[HDR]), 32'h11);
        chk("single_b1", 32'(cap[HDR + 1]), 32'h22);
        chk("single_b2", 32'(cap[HDR + 2]), 32'h33);
        chk("single_gcyc", 32'(gcyc), 32'(3 + HDR));

        // Fairness: all sources with back-to-back 1-byte packets
        reset_dut();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NI; i++) push(i, 8'($urandom), 1);
        repeat (60) step();
        chk("fair_count", 32'(glog_n), 12);
        for (int k = 0; k < 12; k++) chk("fair_order", 32'(glog[k]), 32'(k % NI));

        // Backpressure mid-packet is not a stall
        reset_dut();
        for (int k = 0; k < 6; k++) push(0, 8'(8'h40 + k), (k == 5));
        repeat (3) step();
        p_rdy = 0;
        repeat (20) step();
        p_rdy = 100;
        repeat (10) step();
        chk("bp_stall_err", 32'(serr_cnt), 0);
        chk("bp_len", 32'(cap_n), 32'(6 + HDR));
        for (int k = 0; k < 6; k++) chk("bp_byte", 32'(cap[HDR + k]), 32'(8'h40 + k));

        // Stall abort: source 1 goes quiet after 2 bytes
        reset_dut();
        for (int k = 0; k < 4; k++) push(1, 8'(8'h50 + k), (k == 3));
        push(2, 8'h77, 1);
        for (int t = 0; t < 30 && head[1] < 2; t++) step();
        chk("stall_setup", 32'(head[1]), 2);
        hold = 4'b0010;
        repeat (8) step();
        hold = '0;
        repeat (20) step();
        chk("stall_pulses", 32'(serr_cnt), 1);
        chk("stall_g0", 32'(glog[0]), 1);
        chk("stall_g1", 32'(glog[1]), 2);
        chk("stall_g2", 32'(glog[2]), 1);

        // Flush mid-packet keeps the pointer
        reset_dut();
        push(1, 8'h01, 1);
        repeat (5) step();
        glog_n = 0;
        for (int k = 0; k < 5; k++) push(2, 8'(8'h60 + k), (k == 4));
        push(3, 8'h99, 1);
        for (int t = 0; t < 20 && head[2] < 2; t++) step();
        chk("flush_setup", 32'(head[2]), 2);
        flush_now = 1;
        step();
        flush_now = 0;
        step();
        chk("flush_grant", 32'(grant), 0);
        chk("flush_busy", 32'(busy), 0);
        repeat (30) step();
        chk("flush_count", 32'(glog_n), 3);
        chk("flush_g1", 32'(glog[1]), 2);
        chk("flush_g2", 32'(glog[2]), 3);

        // Randomized traffic with backpressure, gaps and flushes
        reset_dut();
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < 10; p++) begin
                int len;
                len = int'($urandom_range(5, 1));
                for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
            end
        p_vld = 85; p_rdy = 75; p_flush = 2;
        repeat (1500) step();
        p_vld = 100; p_rdy = 100; p_flush = 0;
        left = 1;
        for (int t = 0; t < 2000 && left != 0; t++) begin
            step();
            left = 0;
            for (int i = 0; i < NI; i++) left += tail[i] - head[i];
        end
        chk("drain_left", 32'(left), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
